// File: rtl/microsequencer.sv
// Next-address controller for the 32 x 25-bit microcode store.
// Ports: clock, reset (sync, active high); nssel, dbin, memcntl
//   are fields of the current control word; opcode and mode come from
//   the IR; zero is the ALU flag; mem_ack completes a memory op; halt
//   freezes sequencing. Outputs: address (combinational), mem_req
//   (registered), exec_en (word commits this cycle), illegal (sticky).
module microsequencer #(
    parameter logic [4:0] START_ADDR = 5'd0,
    parameter logic [4:0] TRAP_ADDR  = 5'd31
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] nssel,
    input  logic [4:0] dbin,
    input  logic [2:0] memcntl,
    input  logic [3:0] opcode,
    input  logic [1:0] mode,
    input  logic       zero,
    input  logic       mem_ack,
    input  logic       halt,
    output logic [4:0] address,
    output logic       mem_req,
    output logic       exec_en,
    output logic       illegal
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [4:0] cur_addr, cur_n;
    logic       req_n;
    logic       ill_n;
    logic [4:0] nxt;
    logic       trap;

    always_comb begin
        nxt  = dbin;
        trap = 1'b0;
        unique case (nssel)
            2'b00: nxt = dbin;
            2'b01: begin
                case (opcode)
                    4'd0:    nxt = 5'd9;
                    4'd1:    nxt = 5'd10;
                    4'd2:    nxt = 5'd11;
                    4'd3:    nxt = 5'd12;
                    4'd4:    nxt = 5'd14;
                    4'd5:    nxt = 5'd15;
                    4'd6:    nxt = 5'd16;
                    4'd7:    nxt = 5'd17;
                    4'd8:    nxt = 5'd19;
                    4'd9:    nxt = 5'd21;
                    default: begin
                        nxt  = TRAP_ADDR;
                        trap = 1'b1;
                    end
                endcase
            end
            2'b10: begin
                case (mode)
                    2'd0:    nxt = 5'd10;
                    2'd1:    nxt = 5'd11;
                    2'd2:    nxt = 5'd12;
                    default: nxt = 5'd14;
                endcase
            end
            2'b11: nxt = dbin + {4'd0, zero};
            default: nxt = dbin;
        endcase
    end

    always_comb begin
        state_n = state;
        cur_n   = cur_addr;
        req_n   = mem_req;
        address = cur_addr;
        exec_en = 1'b0;
        unique case (state)
            BOOT: begin
                address = START_ADDR;
                state_n = RUN;
            end
            RUN: begin
                if (halt) begin
                    state_n = HALTED;
                end else if (memcntl != 3'b000) begin
                    req_n   = 1'b1;
                    state_n = MEMWAIT;
                end else begin
                    address = nxt;
                    exec_en = 1'b1;
                    cur_n   = nxt;
                end
            end
            MEMWAIT: begin
                if (mem_ack) begin
                    address = nxt;
                    exec_en = 1'b1;
                    cur_n   = nxt;
                    req_n   = 1'b0;
                    state_n = RUN;
                end
            end
            HALTED: begin
                // Releasing halt re-evaluates the held word in RUN.
                if (!halt) state_n = RUN;
            end
            default: state_n = BOOT;
        endcase
        if (reset) begin
            address = START_ADDR;
            exec_en = 1'b0;
        end
        // Only a committed trap dispatch marks the opcode as illegal.
        ill_n = illegal | (exec_en & trap);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= BOOT;
            cur_addr <= START_ADDR;
            mem_req  <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state    <= state_n;
            cur_addr <= cur_n;
            mem_req  <= req_n;
            illegal  <= ill_n;
        end
    end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Next-address controller for the 32 x 25-bit microcode control store, which registers its control word on the clock edge after the address is presented.
- Each cycle, computes the next 5-bit control-store address from the current word's next-state fields (nssel, dbin), the instruction register opcode and mode, and the ALU zero flag.
- Stalls sequencing (re-presents the same address) while a memory operation awaits acknowledge, or while halt is high.
- Provides a one-cycle execute enable so the datapath commits each microinstruction exactly once.

Parameters:
- START_ADDR, 5'd0, reset/boot address (start0).
- TRAP_ADDR, 5'd31, dispatch target for undefined opcodes.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- nssel  in  2  next-state select field of the current control word.
- dbin  in  5  direct-branch address field of the current control word.
- memcntl  in  3  memory-control field of the current control word; 3'b000 = no memory op.
- opcode  in  4  IR opcode, for nssel=01 dispatch.
- mode  in  2  IR addressing-mode bits, for nssel=10 dispatch.
- zero  in  1  ALU zero flag, for nssel=11 branch.
- mem_ack  in  1  memory completion strobe.
- halt  in  1  freeze sequencing while high.
- address  out  5  control-store address (combinational from state and inputs).
- mem_req  out  1  memory request, registered.
- exec_en  out  1  current control word commits this cycle.
- illegal  out  1  sticky flag: undefined opcode was dispatched.

Behaviour:
- State register cur_addr (5b) holds the address of the word now at the control store output.
- FSM states: BOOT, RUN, MEMWAIT, HALTED.
- Reset (sync, has priority over everything):
  - state=BOOT, cur_addr=START_ADDR, mem_req=0, illegal=0.
  - address=START_ADDR, exec_en=0.
- BOOT:
  - address=START_ADDR, exec_en=0.
  - Next cycle -> RUN. The control word at START_ADDR is valid from then on.
- Next-address function nxt:
  - nssel=00: dbin.
  - nssel=01: opcode map: 0->9 brzz1, 1->10 ldrm1, 2->11 strm1, 3->12 oprm1, 4->14 test1, 5->15 ldrr1, 6->16 strr1, 7->17 oprr1, 8->19 popr1, 9->21 push1, 10..15->TRAP_ADDR. A trap dispatch sets illegal=1.
  - nssel=10: mode map: 0->10, 1->11, 2->12, 3->14.
  - nssel=11: zero ? dbin+1 : dbin. The add is 5-bit and wraps (31+1=0).
- RUN, halt=1:
  - address=cur_addr, exec_en=0, -> HALTED.
- RUN, memcntl!=0, halt=0:
  - address=cur_addr, exec_en=0, mem_req<=1, -> MEMWAIT.
- RUN, memcntl=0, halt=0:
  - address=nxt, exec_en=1, cur_addr<=nxt.
- MEMWAIT:
  - mem_req stays 1 and address=cur_addr until mem_ack=1.
  - On the mem_ack cycle: exec_en=1, address=nxt, cur_addr<=nxt, mem_req<=0, -> RUN.
  - halt is ignored in MEMWAIT. The memory op always completes first, and halt is sampled again in RUN.
  - mem_ack seen in RUN or BOOT is ignored.
- HALTED:
  - address=cur_addr, exec_en=0.
  - When halt drops -> RUN. That cycle evaluates the same word again, so there is no lost or duplicated commit.
- Throughput: one microinstruction per cycle with no memory op. A memory op takes 1 + N cycles, where mem_ack arrives N cycles after mem_req rises (N>=1).
- Back-to-back memory words: re-entry to MEMWAIT is from RUN only. mem_req goes low for at least one cycle between requests.
- illegal is cleared only by reset.
- Reset mid-MEMWAIT: mem_req drops on the next edge, and the outstanding ack is ignored.

Test Plan:
- Boot: reset high 2 cycles, then low -> address=0 during BOOT, exec_en=0; the first RUN cycle with word 0 (nssel=00, dbin=23, memcntl=0) drives address=23 and exec_en=1.
- Direct chain: words with nssel=00 and dbin 1->2->3, memcntl=0 -> address steps 1,2,3 on consecutive cycles with exec_en high each cycle.
- Opcode dispatch: nssel=01 with opcode=5 -> address=15. With opcode=12 -> address=31 and illegal=1, which stays 1 until reset.
- Zero branch: nssel=11, dbin=6: zero=1 -> 7, zero=0 -> 6. With dbin=31 and zero=1 -> address wraps to 0.
- Memory stall: memcntl=3'b010 at cur_addr=0, mem_ack after 3 cycles -> mem_req high 3 cycles, address held at 0, exec_en=0 until the ack cycle; exec_en=1 only on the ack cycle with address=nxt.
- Halt/reset: halt raised in RUN holds address for 4 cycles with exec_en=0, then resumes at the same word. halt raised during MEMWAIT has no effect until the ack. Reset asserted during MEMWAIT -> mem_req=0, address=0 next cycle.
